// File: rtl/parity_sched_arb.sv
// parity_sched_arb: round-robin arbiter feeding one shared bit-serial parity
// engine. One requester word is accepted at a time, its parity is folded one
// bit per cycle over DATA_W cycles, and the result is returned with the
// requester index on a valid/ready port.
module parity_sched_arb #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        odd_mode,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic                        res_parity,
   output logic [$clog2(NUM_REQ)-1:0]  res_id,
   output logic                        busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(DATA_W + 1);

   // Wide enough to hold rr_ptr + offset before folding it back into range.
   localparam logic [ID_W:0]      NUM_REQ_X = (ID_W + 1)'(NUM_REQ);
   localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0]   shreg_q,  shreg_d;
   logic                acc_q,    acc_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [ID_W-1:0]     id_q,     id_d;

   logic [DATA_W-1:0]   req_words [NUM_REQ];
   logic [ID_W-1:0]     grant_idx;
   logic                grant_found;
   logic [ID_W:0]       cand;
   logic                accept;

   // Unpack the flat data bus and build the one-hot ready strobe.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_words[gi] = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
   end

   // Round-robin search: first asserted request at or above rr_ptr, wrapping.
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
         if (cand >= NUM_REQ_X) begin
            cand = cand - NUM_REQ_X;
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   // Reset gates the strobe so no grant is shown while reset is asserted.
   assign accept = rst_n && (state_q == IDLE) && grant_found;

   // Next-state logic for the sequencer and the serial parity datapath.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      shreg_d  = shreg_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      id_d     = id_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d  = req_words[grant_idx];
               acc_d    = odd_mode;
               cnt_d    = '0;
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            acc_d   = acc_q ^ shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset discards any in-flight result immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         shreg_q  <= '0;
         acc_q    <= 1'b0;
         cnt_q    <= '0;
         id_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         shreg_q  <= shreg_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         id_q     <= id_d;
      end
   end

   // Result fields are forced to zero outside DONE so idle outputs are clean.
   assign res_valid  = (state_q == DONE);
   assign res_parity = res_valid & acc_q;
   assign res_id     = res_valid ? id_q : '0;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_sched_arb.sv
// Testbench for parity_sched_arb: directed scenarios plus randomized traffic
// checked against a behavioural model (round-robin rule, popcount parity).
module tb_parity_sched_arb;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int ID_W    = $clog2(NUM_REQ);

   localparam int         SGL_REQ [5] = '{0, 2, 2, 2, 2};
   localparam logic [7:0] SGL_DAT [5] = '{8'h00, 8'h07, 8'hFF, 8'hAA, 8'h01};
   localparam logic       SGL_ODD [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam logic       SGL_PAR [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam logic [7:0] ROT_DAT [4] = '{8'h01, 8'h03, 8'h55, 8'hFF};
   localparam int         ROT_ID  [5] = '{0, 1, 2, 3, 0};
   localparam logic       ROT_PAR [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b1;
   logic [NUM_REQ-1:0]         req_valid = '0;
   logic [NUM_REQ*DATA_W-1:0]  req_data = '0;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       odd_mode = 1'b0;
   logic                       res_valid;
   logic                       res_ready = 1'b0;
   logic                       res_parity;
   logic [ID_W-1:0]            res_id;
   logic                       busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int m_ptr    = 0;

   parity_sched_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .odd_mode   (odd_mode),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_parity (res_parity),
      .res_id     (res_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: first valid requester at or after the pointer, wrapping.
   function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
      int idx;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (ptr + k) % NUM_REQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // Reference: even parity is set when the count of ones is odd; odd mode inverts.
   function automatic logic model_parity(input logic [DATA_W-1:0] d, input logic odd);
      return logic'(($countones(d) % 2) == 1) ^ odd;
   endfunction

   // Drives one request, waits for its result and reports what was observed.
   task automatic txn(input logic [NUM_REQ-1:0] vmask, input logic odd, input bit keep,
                      input bit scramble, input int hold,
                      output logic [NUM_REQ-1:0] rdy, output int lat, output logic par,
                      output logic [ID_W-1:0] id, output bit extra_rdy, output bit unstable,
                      output bit not_dropped, output bit busy_bad, output int t_rise);
      lat = -1; par = 1'b0; id = '0; extra_rdy = 0; unstable = 0;
      not_dropped = 0; busy_bad = 0; t_rise = -1;
      req_valid = vmask;
      odd_mode  = odd;
      res_ready = (hold == 0);
      #1;
      rdy = req_ready;
      @(posedge clk); #1;
      if (!keep) req_valid = '0;
      if (req_ready !== '0) extra_rdy = 1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (scramble && n == 3) begin
            odd_mode = ~odd_mode;
            for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
         end
         if (res_valid === 1'b1) begin
            lat = n;
            t_rise = cyc;
            break;
         end
         if (req_ready !== '0) extra_rdy = 1;
         if (busy !== 1'b1) busy_bad = 1;
      end
      if (lat < 0) begin
         $display("txn req=%b rdy=%b no result", vmask, rdy);
         return;
      end
      par = res_parity;
      id  = res_id;
      if (busy !== 1'b1) busy_bad = 1;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (res_valid !== 1'b1 || res_parity !== par || res_id !== id) unstable = 1;
         if (req_ready !== '0) extra_rdy = 1;
         if (busy !== 1'b1) busy_bad = 1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      not_dropped = (res_valid !== 1'b0);
      if (busy !== 1'b0) busy_bad = 1;
      $display("txn req=%b odd=%0b rdy=%b id=%0d par=%0b lat=%0d hold=%0d",
               vmask, odd, rdy, id, par, lat, hold);
   endtask

   task automatic test_reset();
      req_valid = '1; res_ready = 1'b0; odd_mode = 1'b0; req_data = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({req_ready, res_valid, res_parity, res_id, busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got rdy=%b v=%b p=%b id=%0d busy=%b required all zero",
                  req_ready, res_valid, res_parity, res_id, busy);
      end
      req_valid = '0;
      rst_n = 1'b1;
      m_ptr = 0;
      @(posedge clk); #1;
      checks++;
      if ({req_ready, res_valid, busy} !== '0) begin
         failures++;
         $display("FAIL idle_after_reset: got rdy=%b v=%b busy=%b required zero",
                  req_ready, res_valid, busy);
      end
   endtask

   task automatic test_single();
      logic [NUM_REQ-1:0] rdy, er;
      int lat, tr, r;
      logic par;
      logic [ID_W-1:0] id;
      bit xr, us, nd, bb;
      for (int t = 0; t < 5; t++) begin
         r = SGL_REQ[t];
         req_data = '0;
         req_data[r*DATA_W +: DATA_W] = SGL_DAT[t];
         er = '0; er[r] = 1'b1;
         txn(er, SGL_ODD[t], 1'b1, 1'b0, 0, rdy, lat, par, id, xr, us, nd, bb, tr);
         req_valid = '0;
         m_ptr = (r + 1) % NUM_REQ;
         checks++;
         if (rdy !== er) begin
            failures++; $display("FAIL single_ready[%0d]: got %b required %b", t, rdy, er);
         end
         checks++;
         if (lat !== 8) begin
            failures++; $display("FAIL single_latency[%0d]: got %0d required 8", t, lat);
         end
         checks++;
         if (par !== SGL_PAR[t] || id !== ID_W'(r)) begin
            failures++;
            $display("FAIL single_result[%0d]: got par=%b id=%0d required par=%b id=%0d",
                     t, par, id, SGL_PAR[t], r);
         end
         checks++;
         if ({xr, nd, bb} !== 3'b000) begin
            failures++;
            $display("FAIL single_handshake[%0d]: got extra_ready=%b valid_held=%b busy_bad=%b required 000",
                     t, xr, nd, bb);
         end
      end
   endtask

   task automatic test_rotation();
      logic [NUM_REQ-1:0] rdy, er;
      int lat, tr, prev;
      logic par;
      logic [ID_W-1:0] id;
      bit xr, us, nd, bb;
      rst_n = 1'b0;
      req_valid = '1;
      for (int i = 0; i < 4; i++) req_data[i*DATA_W +: DATA_W] = ROT_DAT[i];
      @(posedge clk); #2;
      rst_n = 1'b1;
      m_ptr = 0;
      prev = -1;
      for (int t = 0; t < 5; t++) begin
         txn('1, 1'b0, 1'b1, 1'b0, 0, rdy, lat, par, id, xr, us, nd, bb, tr);
         er = '0; er[ROT_ID[t]] = 1'b1;
         checks++;
         if (rdy !== er || id !== ID_W'(ROT_ID[t])) begin
            failures++;
            $display("FAIL rotation_grant[%0d]: got rdy=%b id=%0d required rdy=%b id=%0d",
                     t, rdy, id, er, ROT_ID[t]);
         end
         checks++;
         if (par !== ROT_PAR[t]) begin
            failures++; $display("FAIL rotation_parity[%0d]: got %b required %b", t, par, ROT_PAR[t]);
         end
         if (t > 0) begin
            checks++;
            if (tr - prev !== 10) begin
               failures++; $display("FAIL rotation_spacing[%0d]: got %0d required 10", t, tr - prev);
            end
         end
         prev = tr;
      end
      req_valid = '0;
      m_ptr = 1;
   endtask

   task automatic test_hold();
      logic [NUM_REQ-1:0] rdy, vm;
      int lat, tr, eg;
      logic par, ep;
      logic [ID_W-1:0] id;
      bit xr, us, nd, bb;
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
         vm = '1;
         eg = model_grant(vm, m_ptr);
         ep = model_parity(req_data[eg*DATA_W +: DATA_W], 1'b1);
         txn(vm, 1'b1, 1'b1, 1'b0, (t == 0) ? 5 : 0, rdy, lat, par, id, xr, us, nd, bb, tr);
         m_ptr = (eg + 1) % NUM_REQ;
         checks++;
         if (id !== ID_W'(eg) || par !== ep) begin
            failures++;
            $display("FAIL hold_result[%0d]: got id=%0d par=%b required id=%0d par=%b", t, id, par, eg, ep);
         end
         checks++;
         if ({us, xr, nd, bb} !== 4'b0000) begin
            failures++;
            $display("FAIL hold_stability[%0d]: got unstable=%b extra_ready=%b valid_held=%b busy_bad=%b required 0000",
                     t, us, xr, nd, bb);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_midshift();
      logic [NUM_REQ-1:0] rdy, vm;
      int lat, tr, eg;
      logic par, ep, odd;
      logic [ID_W-1:0] id;
      bit xr, us, nd, bb;
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
         vm  = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         odd = 1'($urandom_range(0, 1));
         eg  = model_grant(vm, m_ptr);
         ep  = model_parity(req_data[eg*DATA_W +: DATA_W], odd);
         txn(vm, odd, 1'b0, 1'b1, 0, rdy, lat, par, id, xr, us, nd, bb, tr);
         m_ptr = (eg + 1) % NUM_REQ;
         checks++;
         if (par !== ep || id !== ID_W'(eg) || lat !== 8) begin
            failures++;
            $display("FAIL midshift[%0d]: got par=%b id=%0d lat=%0d required par=%b id=%0d lat=8",
                     t, par, id, lat, ep, eg);
         end
      end
   endtask

   task automatic test_random();
      logic [NUM_REQ-1:0] rdy, vm, er;
      int lat, tr, eg, hold;
      logic par, ep, odd;
      logic [ID_W-1:0] id;
      bit xr, us, nd, bb, keep;
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
         vm   = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         odd  = 1'($urandom_range(0, 1));
         hold = $urandom_range(0, 2);
         keep = 1'($urandom_range(0, 1));
         eg   = model_grant(vm, m_ptr);
         ep   = model_parity(req_data[eg*DATA_W +: DATA_W], odd);
         er   = '0; er[eg] = 1'b1;
         txn(vm, odd, keep, 1'($urandom_range(0, 1)), hold, rdy, lat, par, id, xr, us, nd, bb, tr);
         req_valid = '0;
         m_ptr = (eg + 1) % NUM_REQ;
         checks++;
         if (rdy !== er || id !== ID_W'(eg)) begin
            failures++;
            $display("FAIL random_grant[%0d]: got rdy=%b id=%0d required rdy=%b id=%0d (req=%b)",
                     t, rdy, id, er, eg, vm);
         end
         checks++;
         if (par !== ep || lat !== 8) begin
            failures++;
            $display("FAIL random_result[%0d]: got par=%b lat=%0d required par=%b lat=8", t, par, lat, ep);
         end
         checks++;
         if ({us, xr, nd, bb} !== 4'b0000) begin
            failures++;
            $display("FAIL random_protocol[%0d]: got unstable=%b extra_ready=%b valid_held=%b busy_bad=%b required 0000",
                     t, us, xr, nd, bb);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [NUM_REQ-1:0] rdy;
      int lat, tr;
      logic par, ep;
      logic [ID_W-1:0] id;
      bit xr, us, nd, bb;
      for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      req_valid = 4'b0010; odd_mode = 1'b0; res_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 4'b1000;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL midreset_inflight: got busy=%b required 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, res_valid, res_parity, res_id, busy} !== '0) begin
         failures++;
         $display("FAIL midreset_async: got rdy=%b v=%b p=%b id=%0d busy=%b required all zero",
                  req_ready, res_valid, res_parity, res_id, busy);
      end
      @(posedge clk); #1;
      checks++;
      if ({req_ready, res_valid, busy} !== '0) begin
         failures++;
         $display("FAIL midreset_held: got rdy=%b v=%b busy=%b required zero", req_ready, res_valid, busy);
      end
      rst_n = 1'b1;
      m_ptr = 0;
      ep = model_parity(req_data[3*DATA_W +: DATA_W], 1'b0);
      txn(4'b1000, 1'b0, 1'b0, 1'b0, 0, rdy, lat, par, id, xr, us, nd, bb, tr);
      m_ptr = model_grant(4'b1000, 0) + 1;
      checks++;
      if (rdy !== 4'b1000 || id !== ID_W'(3)) begin
         failures++;
         $display("FAIL midreset_regrant: got rdy=%b id=%0d required rdy=1000 id=3", rdy, id);
      end
      checks++;
      if (lat !== 8 || par !== ep) begin
         failures++;
         $display("FAIL midreset_no_stale: got lat=%0d par=%b required lat=8 par=%b", lat, par, ep);
      end
      m_ptr = m_ptr % NUM_REQ;
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_hold();
      test_midshift();
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
